// File: rtl/oled_scanner_pkg.sv
// Shared geometry, state encoding and address helper for the CHIP-8 to SSD1306 scanner.
package oled_scanner_pkg;

    localparam int unsigned SCREEN_W      = 64;
    localparam int unsigned SCREEN_H      = 32;
    localparam int unsigned BYTES_PER_ROW = 8;
    localparam int unsigned OLED_PAGES    = 8;
    localparam int unsigned OLED_COLS     = 128;

    localparam int unsigned ROWS_PER_PAGE = SCREEN_H / OLED_PAGES;
    localparam int unsigned BUF_DEPTH     = ROWS_PER_PAGE * BYTES_PER_ROW;
    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned IDX_W         = $clog2(BUF_DEPTH);
    localparam int unsigned COL_W         = $clog2(OLED_COLS);
    localparam int unsigned PAGE_W        = $clog2(OLED_PAGES);
    localparam int unsigned X_W           = $clog2(SCREEN_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_ADDR,
        ST_FETCH_DATA,
        ST_EMIT,
        ST_DONE
    } state_t;

    // One OLED page covers 32 consecutive framebuffer bytes, so page*32+idx is a plain concat.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [PAGE_W-1:0] page,
                                                  input logic [IDX_W-1:0]  idx);
        return base + ADDR_W'({page, idx});
    endfunction

endpackage

// File: rtl/oled_page_buf.sv
// 32x8 page buffer (four CHIP-8 rows) with a combinational 2x-scaled SSD1306 column read.
module oled_page_buf
    import oled_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [X_W-1:0]    rd_x,
    output logic [DATA_W-1:0] rd_byte_c
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Output bit pairs (2r, 2r+1) both show row r of the page: vertical doubling.
    always_comb begin
        rd_byte_c = '0;
        for (int k = 0; k < DATA_W; k++) begin
            rd_byte_c[k] = mem[{2'(k >> 1), rd_x[5:3]}][~rd_x[2:0]];
        end
    end

endmodule

// File: rtl/oled_scanner.sv
// Scans the CHIP-8 framebuffer page by page and streams 2x-scaled SSD1306 column bytes.
module oled_scanner
    import oled_scanner_pkg::*;
#(
    parameter logic [ADDR_W-1:0] screen_start = 16'h0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    input  logic              mem_grant,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_read_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_byte,
    output logic              out_first
);

    state_t              state;
    logic [PAGE_W-1:0]   page;
    logic [IDX_W-1:0]    idx;
    logic [COL_W-1:0]    col;
    logic [X_W-1:0]      rd_x_c;
    logic [DATA_W-1:0]   col_byte_c;

    // The strobe must follow this cycle's grant, so it cannot be registered.
    assign mem_read = (state == ST_FETCH_ADDR) && mem_grant;

    // Look ahead to the column that will be presented after a handshake.
    assign rd_x_c = col[COL_W-1:1] + X_W'(out_valid & col[0]);

    oled_page_buf u_page_buf (
        .clk       (clk),
        .wr_en     (state == ST_FETCH_DATA),
        .wr_idx    (idx),
        .wr_data   (mem_read_byte),
        .rd_x      (rd_x_c),
        .rd_byte_c (col_byte_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            mem_addr   <= '0;
            out_byte   <= '0;
            page       <= '0;
            idx        <= '0;
            col        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        page     <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        mem_addr <= fb_addr(screen_start, '0, '0);
                        state    <= ST_FETCH_ADDR;
                    end
                end
                ST_FETCH_ADDR: begin
                    if (mem_grant) begin
                        state <= ST_FETCH_DATA;
                    end
                end
                ST_FETCH_DATA: begin
                    if (idx == IDX_W'(BUF_DEPTH - 1)) begin
                        col   <= '0;
                        state <= ST_EMIT;
                    end else begin
                        idx      <= IDX_W'(idx + 1'b1);
                        mem_addr <= fb_addr(screen_start, page, IDX_W'(idx + 1'b1));
                        state    <= ST_FETCH_ADDR;
                    end
                end
                ST_EMIT: begin
                    // First cycle of a page loads the byte; out_valid rises with it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_byte  <= col_byte_c;
                        out_first <= (page == '0) && (col == '0);
                    end else if (out_ready) begin
                        out_first <= 1'b0;
                        if (col != COL_W'(OLED_COLS - 1)) begin
                            col      <= COL_W'(col + 1'b1);
                            out_byte <= col_byte_c;
                        end else begin
                            out_valid <= 1'b0;
                            if (page != PAGE_W'(OLED_PAGES - 1)) begin
                                page     <= PAGE_W'(page + 1'b1);
                                idx      <= '0;
                                mem_addr <= fb_addr(screen_start, PAGE_W'(page + 1'b1), '0);
                                state    <= ST_FETCH_ADDR;
                            end else begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_scanner.sv
// Bench for oled_scanner: framebuffer memory model, pixel-level expected frame, per-handshake compare.
module tb_oled_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        mem_grant = 1'b1;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [7:0]  mem_read_byte = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_first;

    oled_scanner #(.screen_start(16'h0100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .frame_done    (frame_done),
        .mem_grant     (mem_grant),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_read_byte (mem_read_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_byte      (out_byte),
        .out_first     (out_first)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_read) mem_read_byte <= mem[mem_addr];
    end

    int         checks = 0;
    int         failures = 0;
    int         cnt = 0;
    int         done_cnt = 0;
    bit         mon_en = 1'b0;
    bit         grant_rand = 1'b0;
    bit         stall_en = 1'b0;
    bit         stall_done = 1'b0;
    int         stall_left = 0;
    logic [7:0] exp_b [1024];
    logic [7:0] got   [1024];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_first = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Expected byte n of the frame: OLED pixel (col, page*8+k) is CHIP-8 pixel (col/2, y/2).
    function automatic logic [7:0] model_byte(input int n);
        int         pg, c, x, y;
        logic [7:0] fb, r;
        pg = n / 128;
        c  = n % 128;
        x  = c / 2;
        r  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            y    = (pg * 8 + k) / 2;
            fb   = mem[16'h0100 + y * 8 + x / 8];
            r[k] = fb[7 - (x % 8)];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        check("mem_read_without_grant", 32'(mem_read & ~mem_grant), 32'd0);
        if (frame_done) done_cnt++;
        if (mon_en) begin
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_byte", 32'(out_byte), 32'(prev_byte));
                check("stall_first", 32'(out_first), 32'(prev_first));
            end
            if (out_valid && out_ready) begin
                if (cnt < 1024) begin
                    check($sformatf("byte%0d", cnt), 32'(out_byte), 32'(exp_b[cnt]));
                    check($sformatf("first%0d", cnt), 32'(out_first), 32'(cnt == 0));
                    got[cnt] = out_byte;
                end else begin
                    check("byte_overrun", 32'(cnt), 32'd1023);
                end
                cnt++;
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_byte  = out_byte;
        prev_first = out_first;
    end

    // Grant and ready drivers, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_grant = grant_rand ? ($urandom_range(0, 3) < 2) : 1'b1;
            if (stall_en && !stall_done && stall_left == 0 && out_valid && cnt == 168)
                stall_left = 5;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) stall_done = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic run_frame(input string name);
        int cyc;
        for (int n = 0; n < 1024; n++) exp_b[n] = model_byte(n);
        cnt = 0;
        done_cnt = 0;
        mon_en = 1'b1;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(posedge clk); #2;
            start = (cyc == 200);
            cyc++;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check({name, "_count"}, 32'(cnt), 32'd1024);
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        rst_n = 1'b1;

        run_frame("zero");

        mem[16'h0100] = 8'h80;
        run_frame("pix00");
        check("pix00_b0", 32'(got[0]), 32'h03);
        check("pix00_b1", 32'(got[1]), 32'h03);
        check("pix00_b2", 32'(got[2]), 32'h00);
        check("pix00_b128", 32'(got[128]), 32'h00);
        mem[16'h0100] = 8'h00;

        mem[16'h0100 + 31 * 8 + 7] = 8'h01;
        run_frame("pix6331");
        check("pix6331_b1022", 32'(got[1022]), 32'hC0);
        check("pix6331_b1023", 32'(got[1023]), 32'hC0);
        check("pix6331_b1021", 32'(got[1021]), 32'h00);
        check("pix6331_b894", 32'(got[894]), 32'h00);
        mem[16'h0100 + 31 * 8 + 7] = 8'h00;

        for (int i = 0; i < 256; i++) mem[16'h0100 + i] = 8'(i * 37 + 5);
        run_frame("pattern");
        grant_rand = 1'b1;
        run_frame("grant_rand");
        grant_rand = 1'b0;
        stall_en = 1'b1;
        run_frame("stall");
        check("stall_happened", 32'(stall_done), 32'd1);
        stall_en = 1'b0;

        // Abandon a frame during page 3 emission.
        for (int n = 0; n < 1024; n++) exp_b[n] = model_byte(n);
        cnt = 0;
        done_cnt = 0;
        mon_en = 1'b1;
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        cyc = 0;
        while (cnt < 3 * 128 + 10 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check("reach_page3", 32'(cnt >= 3 * 128 + 10), 32'd1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        run_frame("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
